uart_rx_stop_check: RTL and testbench
=====================================

// Module: uart_rx_stop_check
// PURPOSE
//  Stop-bit timer/checker for the UART receiver, successor to the fixed stop-bit timer.
//  Runtime-selectable stop length (1, 1.5, 2 bits). Majority-of-3 sampling at each stop-bit centre.
//  Flags framing errors and break conditions.
//  Started by the RX sequencer after the last data bit. Clocked by oversample strobe i_en.
// PARAMETERS
//  OSR        16  oversample ticks per bit; even, >= 8
//  CNT_W      $clog2(2*OSR+1)  tick counter width (derived, do not override)
// PORTS
//  i_clk         in   1  system clock
//  i_rst         in   1  reset, asynchronous, active-high
//  i_en          in   1  oversample tick strobe (one-cycle pulses)
//  i_rx          in   1  synchronised RX line
//  i_start       in   1  one-cycle pulse: begin stop-bit period
//  i_stop_cfg    in   2  0=1 bit, 1=1.5 bits, 2=2 bits, 3=treated as 2
//  i_data_zero   in   1  all data bits of current frame were 0 (for break detect)
//  o_ready       out  1  one-cycle pulse: stop period complete
//  o_busy        out  1  high while in SAMPLE state
//  o_frame_err   out  1  framing error of last completed frame
//  o_break       out  1  break detected on last completed frame
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, all outputs 0, vote/err accumulators cleared.
//  Async reset mid-period aborts immediately; no o_ready for the aborted frame.
//  States: IDLE -> SAMPLE on i_start.
//   SAMPLE -> IDLE on completing tick TOTAL; o_ready pulses on that edge.
//  i_stop_cfg is latched on i_start; changes during SAMPLE are ignored.
//  Tick n = n-th i_en pulse after i_start (n=1..TOTAL); cnt holds while i_en=0.
//  TOTAL: cfg0=OSR, cfg1=3*OSR/2, cfg2/3=2*OSR.
//  Sample centres M: stop bit 0 at OSR/2.
//   Stop bit 1 at OSR+OSR/2 (cfg2/3) or OSR+OSR/4 (cfg1 half bit).
//  At each centre, i_rx is captured on ticks M-1, M, M+1; majority of 3 = bit value.
//  bad = any voted stop bit is 0. all_low = every voted stop bit is 0.
//  At tick TOTAL (registered, same edge as o_ready):
//   o_frame_err <= bad
//   o_break <= bad & all_low & i_data_zero
//  o_frame_err/o_break hold until the next completion, i_start, or reset.
//  Latency: o_ready rises on the clock edge where i_en is high and cnt==TOTAL-1.
//  o_ready is 1 cycle wide regardless of i_en spacing.
//  i_start while SAMPLE restarts the period: cnt=0, accumulators cleared, flags cleared, cfg relatched.
//  i_start and i_en on the same cycle: start wins; that tick is not counted.
//  i_en while IDLE has no effect.
//  o_busy = (state==SAMPLE); it falls on the same edge o_ready rises.
//  Counter never wraps: saturates path impossible since SAMPLE exits at TOTAL <= 2*OSR.
// TESTING (OSR=16, i_en every cycle unless stated)
//  cfg0, rx=1, start -> o_ready pulse on tick 16; frame_err=0, break=0, busy low after.
//  cfg2, rx=0 on ticks 23..25 only -> ready on tick 32; frame_err=1, break=0.
//  cfg0, rx=0 on tick 8 only (single glitch) -> majority holds 1, frame_err=0.
//  cfg1, rx=0 for all ticks, i_data_zero=1 -> ready on tick 24; frame_err=1, break=1.
//  Timing: i_en every 3rd cycle, restart pulse at tick 10 -> ready at tick 16 after restart.
//   Exactly one o_ready pulse.
//  Reset: assert i_rst at tick 5 -> outputs 0 immediately; no o_ready afterwards until a new i_start.

Source files
------------

// File: rtl/uart_rx_stop_check.sv
// uart_rx_stop_check: stop-bit timer with majority-of-3 voting, framing-error and break flags
module uart_rx_stop_check #(
    parameter int OSR = 16,
    localparam int CNT_W = $clog2(2*OSR+1)
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_rx,
    input  logic       i_start,
    input  logic [1:0] i_stop_cfg,
    input  logic       i_data_zero,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_break
);
    typedef enum logic {IDLE, SAMPLE} state_t;

    localparam logic [CNT_W-1:0] M0  = CNT_W'(OSR/2);
    localparam logic [CNT_W-1:0] M1F = CNT_W'(OSR + OSR/2);
    localparam logic [CNT_W-1:0] M1H = CNT_W'(OSR + OSR/4);
    localparam logic [CNT_W-1:0] T1  = CNT_W'(OSR);
    localparam logic [CNT_W-1:0] T15 = CNT_W'(3*OSR/2);
    localparam logic [CNT_W-1:0] T2  = CNT_W'(2*OSR);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cfg_q, cfg_d;
    logic [1:0]       ones_q, ones_d;
    logic             bad_q, bad_d;
    logic             all_low_q, all_low_d;
    logic             frame_err_q, frame_err_d;
    logic             break_q, break_d;
    logic             ready_q, ready_d;

    logic [CNT_W-1:0] tick, m1, total;
    logic [1:0]       sum;
    logic             two_bits, in_win, vote_now;

    always_comb begin
        tick     = cnt_q + 1'b1;
        two_bits = cfg_q != 2'd0;
        m1       = cfg_q == 2'd1 ? M1H : M1F;
        total    = cfg_q == 2'd0 ? T1 : cfg_q == 2'd1 ? T15 : T2;
        sum      = ones_q + {1'b0, i_rx};
        in_win   = (tick >= M0 - 1'b1 && tick <= M0 + 1'b1) ||
                   (two_bits && tick >= m1 - 1'b1 && tick <= m1 + 1'b1);
        vote_now = tick == M0 + 1'b1 || (two_bits && tick == m1 + 1'b1);
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        ones_d      = ones_q;
        bad_d       = bad_q;
        all_low_d   = all_low_q;
        frame_err_d = frame_err_q;
        break_d     = break_q;
        ready_d     = 1'b0;
        if (i_start) begin
            state_d     = SAMPLE;
            cnt_d       = '0;
            cfg_d       = i_stop_cfg;
            ones_d      = '0;
            bad_d       = 1'b0;
            all_low_d   = 1'b1;
            frame_err_d = 1'b0;
            break_d     = 1'b0;
        end else if (state_q == SAMPLE && i_en) begin
            cnt_d = tick;
            if (in_win) ones_d = sum;
            // third sample of a centre: sum[1] is the majority vote
            if (vote_now) begin
                ones_d    = '0;
                bad_d     = bad_q | ~sum[1];
                all_low_d = all_low_q & ~sum[1];
            end
            if (tick == total) begin
                state_d     = IDLE;
                cnt_d       = '0;
                ready_d     = 1'b1;
                frame_err_d = bad_d;
                break_d     = bad_d & all_low_d & i_data_zero;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cfg_q       <= '0;
            ones_q      <= '0;
            bad_q       <= 1'b0;
            all_low_q   <= 1'b1;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_q       <= cfg_d;
            ones_q      <= ones_d;
            bad_q       <= bad_d;
            all_low_q   <= all_low_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
            ready_q     <= ready_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_busy      = state_q == SAMPLE;
    assign o_frame_err = frame_err_q;
    assign o_break     = break_q;
endmodule

// File: tb/tb_uart_rx_stop_check.sv
// tb_uart_rx_stop_check: directed frames with a scoreboard queue checked by an o_ready monitor
module tb_uart_rx_stop_check;
    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_start = 1'b0;
    logic [1:0] i_stop_cfg = 2'd0;
    logic       i_data_zero = 1'b0;
    logic       o_ready, o_busy, o_frame_err, o_break;

    typedef struct {
        int   edge_no;
        logic fe;
        logic brk;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   readies = 0;

    uart_rx_stop_check #(.OSR(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_en(i_en), .i_rx(i_rx), .i_start(i_start),
        .i_stop_cfg(i_stop_cfg), .i_data_zero(i_data_zero), .o_ready(o_ready),
        .o_busy(o_busy), .o_frame_err(o_frame_err), .o_break(o_break)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!i_rst && o_ready) begin
            readies++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready actual=1 expected=0 cyc=%0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ready_edge", cyc, e.edge_no);
                check("frame_err", int'(o_frame_err), int'(e.fe));
                check("break", int'(o_break), int'(e.brk));
                check("busy_at_ready", int'(o_busy), 0);
            end
        end
    end

    // rx is low on ticks lo_a..lo_b; restart_at>0 re-pulses i_start on that tick
    task automatic frame(input logic [1:0] cfg, input logic dz, input int lo_a, input int lo_b,
                         input int per, input int tot, input int restart_at,
                         input logic fe, input logic brk);
        exp_t e;
        int   n;
        bit   rs;
        @(posedge clk); #1;
        i_start = 1'b1; i_stop_cfg = cfg; i_data_zero = dz; i_en = 1'b0; i_rx = 1'b1;
        e.edge_no = cyc + 1 + tot * per; e.fe = fe; e.brk = brk;
        sb.push_back(e);
        @(posedge clk); #1;
        i_start = 1'b0; i_stop_cfg = 2'd0;
        n = 0; rs = 0;
        while (n < tot) begin
            for (int k = 1; k < per; k++) begin
                i_en = 1'b0;
                @(posedge clk); #1;
            end
            n++;
            i_en = 1'b1;
            i_rx = (n >= lo_a && n <= lo_b) ? 1'b0 : 1'b1;
            if (!rs && n == restart_at) begin
                rs = 1;
                i_start = 1'b1; i_stop_cfg = cfg;
                void'(sb.pop_back());
                e.edge_no = cyc + 1 + tot * per;
                sb.push_back(e);
                n = 0;
            end
            @(posedge clk); #1;
            i_start = 1'b0; i_stop_cfg = 2'd0;
        end
        i_en = 1'b0; i_rx = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", int'({o_ready, o_busy, o_frame_err, o_break}), 0);
        i_rst = 1'b0;
        i_en = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("idle_en_busy", int'(o_busy), 0);
        i_en = 1'b0;

        frame(2'd0, 1'b0, 0, -1, 1, 16, 0, 1'b0, 1'b0);
        frame(2'd2, 1'b0, 23, 25, 1, 32, 0, 1'b1, 1'b0);
        frame(2'd0, 1'b0, 8, 8, 1, 16, 0, 1'b0, 1'b0);
        frame(2'd1, 1'b1, 1, 24, 1, 24, 0, 1'b1, 1'b1);
        frame(2'd0, 1'b0, 0, -1, 3, 16, 10, 1'b0, 1'b0);
        frame(2'd3, 1'b1, 0, -1, 1, 32, 0, 1'b0, 1'b0);
        frame(2'd2, 1'b1, 7, 9, 1, 32, 0, 1'b1, 1'b0);

        @(posedge clk); #1;
        i_start = 1'b1; i_stop_cfg = 2'd0; i_rx = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("busy_mid_frame", int'(o_busy), 1);
        i_rst = 1'b1;
        #1;
        check("async_reset_outputs", int'({o_ready, o_busy, o_frame_err, o_break}), 0);
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        i_en = 1'b0;

        for (int w = 0; w < 50 && sb.size() != 0; w++) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);
        check("ready_count", readies, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
